// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage control unit and data_memory_ctrl.
// master: MEM stage control side; slave: memory controller side.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic                  MemEnable;
  logic                  MemRd;
  logic                  MemWr;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     data_out;
  logic                  MemReady;
  logic                  MemValid;
  logic                  MemDone;
  logic                  MemErr;

  modport master (
    output MemEnable, MemRd, MemWr, address, data_in, byte_en,
    input  data_out, MemReady, MemValid, MemDone, MemErr
  );

  modport slave (
    input  MemEnable, MemRd, MemWr, address, data_in, byte_en,
    output data_out, MemReady, MemValid, MemDone, MemErr
  );

endinterface

// File: rtl/data_memory_ctrl.sv
// Handshaked, parametrised data memory with wait states, byte-masked writes
// and error reporting for out-of-range or contradictory (read+write) requests.
// Build option: define MEM_BYTE_MASK_EN to honour byte_en on writes; when it
// is undefined every write updates the full word and byte_en is ignored.
module data_memory_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               reset_n,
  data_memory_ctrl_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [3:0]          cnt_q;

  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       be_q;
  logic                rd_q;
  logic                err_q;
  logic [NB-1:0]       be_eff;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   rdata_q;
  logic                valid_q;
  logic                done_q;
  logic                merr_q;

  logic                req;
  logic                accept;
  logic                in_range;

  assign req      = bus.MemEnable && (bus.MemRd || bus.MemWr);
  assign accept   = (state == S_IDLE) && req;
  assign in_range = ({1'b0, bus.address} < DEPTH_L);

`ifdef MEM_BYTE_MASK_EN
  assign be_eff = be_q;
`else
  logic unused_be;
  assign be_eff    = '1;
  assign unused_be = ^be_q;
`endif

  assign bus.MemReady = (state == S_IDLE);
  assign bus.MemValid = valid_q;
  assign bus.MemDone  = done_q;
  assign bus.MemErr   = merr_q;
  assign bus.data_out = rdata_q;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) ACCESS -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter reaches zero on this edge.
        if (cnt_q == 4'd1) begin
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if (state == S_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Request capture: everything the access needs is frozen at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= bus.address[IDX_W-1:0];
      wdata_q <= bus.data_in;
      be_q    <= bus.byte_en;
      rd_q    <= bus.MemRd;
      err_q   <= (bus.MemRd && bus.MemWr) || !in_range;
    end
  end

  // Response registers: one-cycle pulses and read data, set on the ACCESS exit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      merr_q  <= 1'b0;
      if (state == S_ACCESS) begin
        if (err_q) begin
          done_q <= 1'b1;
          merr_q <= 1'b1;
        end else if (rd_q) begin
          valid_q <= 1'b1;
          rdata_q <= mem[idx_q];
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

  // Storage write, byte-wise; the array itself is never reset.
  always_ff @(posedge clk) begin
    if ((state == S_ACCESS) && !err_q && !rd_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be_eff[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
